// File: rtl/decim_frame_if.sv
// Sample/config inputs and the frame result bus of the frame decimator.
// The master drives samples and config; the slave returns data_out/valid_out.
interface decim_frame_if #(
  parameter int IN_W     = 12,
  parameter int MAX_LOG2 = 9,
  parameter int OUT_W    = IN_W + 2*MAX_LOG2
);
  localparam int LW = $clog2(MAX_LOG2+1);

  logic             en;
  logic [IN_W-1:0]  data_in;
  logic [1:0]       mode;
  logic [LW-1:0]    osr_log2;
  logic             sync;
  logic [OUT_W-1:0] data_out;
  logic             valid_out;

  modport master (
    output en, data_in, mode, osr_log2, sync,
    input  data_out, valid_out
  );

  modport slave (
    input  en, data_in, mode, osr_log2, sync,
    output data_out, valid_out
  );
endinterface

// File: rtl/decim_frame.sv
// Frame decimator: sample-hold, sinc1 or sinc2 over 2^osr_log2 samples.
// Integrators restart every frame; one registered result word per frame.
module decim_frame #(
  parameter int IN_W     = 12,
  parameter int MAX_LOG2 = 9,
  parameter int OUT_W    = IN_W + 2*MAX_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  decim_frame_if.slave  io
);
  localparam int LW  = $clog2(MAX_LOG2+1);
  localparam int A1W = IN_W + MAX_LOG2;

  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [A1W-1:0]      acc1_q, acc1_d;
  logic [OUT_W-1:0]    acc2_q, acc2_d;
  logic [1:0]          mode_q, mode_d;
  logic [LW-1:0]       log2_q, log2_d;
  logic [OUT_W-1:0]    dout_q, dout_d;
  logic                vld_q, vld_d;

  logic                first;
  logic [1:0]          eff_mode;
  logic [LW-1:0]       eff_log2;
  logic [LW-1:0]       clamp_log2;
  logic [MAX_LOG2-1:0] lim;
  logic [A1W-1:0]      a1n;
  logic [OUT_W-1:0]    a2n;

  always_comb begin
    first      = (cnt_q == '0);
    clamp_log2 = (io.osr_log2 > LW'(MAX_LOG2)) ?
                 LW'(MAX_LOG2) : io.osr_log2;
    // The first sample of a frame runs with the config it latches.
    eff_mode   = first ? io.mode : mode_q;
    eff_log2   = first ? clamp_log2 : log2_q;
    lim        = ~({MAX_LOG2{1'b1}} << eff_log2);
    a1n        = acc1_q + A1W'(io.data_in);
    a2n        = acc2_q + OUT_W'(a1n);

    cnt_d  = cnt_q;
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    mode_d = mode_q;
    log2_d = log2_q;
    dout_d = dout_q;
    vld_d  = 1'b0;

    if (io.sync) begin
      cnt_d  = '0;
      acc1_d = '0;
      acc2_d = '0;
    end else if (io.en) begin
      if (first) begin
        mode_d = io.mode;
        log2_d = clamp_log2;
      end
      if (cnt_q == lim) begin
        unique case (eff_mode)
          2'd0:    dout_d = OUT_W'(io.data_in);
          2'd2:    dout_d = a2n;
          default: dout_d = OUT_W'(a1n);
        endcase
        vld_d  = 1'b1;
        cnt_d  = '0;
        acc1_d = '0;
        acc2_d = '0;
      end else begin
        cnt_d  = cnt_q + MAX_LOG2'(1);
        acc1_d = a1n;
        acc2_d = a2n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      mode_q <= 2'd0;
      log2_q <= LW'(MAX_LOG2);
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      mode_q <= mode_d;
      log2_q <= log2_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign io.data_out  = dout_q;
  assign io.valid_out = vld_q;
endmodule

// File: tb/tb_decim_frame.sv
// Directed bench for decim_frame: per-cycle vector table plus
// long-frame sequences for sample-hold, sinc1 clamp and sinc2 range.
module tb_decim_frame;
  logic clk = 1'b0;
  logic rst_n;

  decim_frame_if #(.IN_W(12), .MAX_LOG2(9)) io ();

  decim_frame #(.IN_W(12), .MAX_LOG2(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        sync;
    logic [1:0]  mode;
    logic [3:0]  osr;
    logic [11:0] din;
    logic        ev;
    logic [29:0] ed;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic e, input logic s,
                     input int m, input int o, input int d,
                     input logic ev, input longint ed);
    vec_t v;
    v.rst_n = r;
    v.en    = e;
    v.sync  = s;
    v.mode  = 2'(m);
    v.osr   = 4'(o);
    v.din   = 12'(d);
    v.ev    = ev;
    v.ed    = 30'(ed);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic s,
                       input int m, input int o, input int d);
    rst_n       = r;
    io.en       = e;
    io.sync     = s;
    io.mode     = 2'(m);
    io.osr_log2 = 4'(o);
    io.data_in  = 12'(d);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    chk("reset_valid", longint'(io.valid_out), 0);
    chk("reset_data", longint'(io.data_out), 0);
  endtask

  task automatic run_const(input string nm, input int m, input int o,
                           input int d, input int ncyc, input int per,
                           input longint expv);
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b1, 1'b1, 1'b0, m, o, d);
      @(posedge clk); #1;
      chk({nm, "_valid"}, longint'(io.valid_out),
          longint'(i % per == per - 1));
      if (i % per == per - 1)
        chk({nm, "_data"}, longint'(io.data_out), expv);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);

    // rst en sync mode osr din | valid data
    add(0, 0, 0, 0, 0, 0,  0, 0);
    add(1, 1, 0, 2, 2, 1,  0, 0);
    add(1, 1, 0, 2, 2, 2,  0, 0);
    add(1, 1, 0, 2, 2, 3,  0, 0);
    add(1, 1, 0, 2, 2, 4,  1, 20);
    add(1, 0, 0, 2, 2, 0,  0, 20);
    add(1, 1, 0, 1, 2, 10, 0, 20);
    add(1, 0, 0, 1, 2, 99, 0, 20);
    add(1, 1, 0, 1, 2, 10, 0, 20);
    add(1, 0, 0, 1, 2, 99, 0, 20);
    add(1, 1, 0, 1, 2, 10, 0, 20);
    add(1, 0, 0, 1, 2, 99, 0, 20);
    add(1, 1, 0, 1, 2, 10, 1, 40);
    add(1, 0, 0, 1, 2, 99, 0, 40);
    add(1, 1, 0, 1, 2, 5,  0, 40);
    add(1, 1, 0, 1, 2, 5,  0, 40);
    add(1, 1, 0, 1, 2, 5,  0, 40);
    add(1, 1, 1, 1, 2, 7,  0, 40);
    add(1, 1, 0, 2, 2, 1,  0, 40);
    add(1, 1, 0, 1, 0, 1,  0, 40);
    add(1, 1, 0, 0, 3, 1,  0, 40);
    add(1, 1, 0, 1, 0, 1,  1, 10);
    add(1, 1, 0, 1, 0, 3,  1, 3);
    add(1, 1, 0, 1, 0, 4,  1, 4);
    add(1, 1, 0, 1, 0, 5,  1, 5);
    add(1, 0, 0, 1, 0, 0,  0, 5);
    add(1, 1, 0, 3, 1, 6,  0, 5);
    add(1, 1, 0, 3, 1, 7,  1, 13);
    add(1, 1, 0, 1, 2, 9,  0, 13);
    add(1, 1, 0, 1, 2, 9,  0, 13);
    add(0, 1, 1, 1, 2, 9,  0, 0);
    add(1, 1, 0, 1, 1, 2,  0, 0);
    add(1, 1, 0, 1, 1, 3,  1, 5);
    add(1, 1, 0, 0, 1, 8,  0, 5);
    add(1, 1, 0, 0, 1, 11, 1, 11);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].sync,
            int'(tbl[i].mode), int'(tbl[i].osr), int'(tbl[i].din));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), longint'(io.valid_out),
          longint'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), longint'(io.data_out),
          longint'(tbl[i].ed));
    end

    // Sample-hold at N=512 with a ramp input.
    do_reset();
    for (int i = 0; i < 3*512; i++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 9, i % 4096);
      @(posedge clk); #1;
      chk("hold_valid", longint'(io.valid_out),
          longint'(i % 512 == 511));
      if (i % 512 == 511)
        chk("hold_data", longint'(io.data_out), longint'(i));
    end

    do_reset();
    run_const("sinc1_n8", 1, 3, 4095, 16, 8, 32760);
    run_const("sinc1_clamp", 1, 12, 4095, 512, 512, 2096640);
    run_const("sinc2_n512", 2, 9, 4095, 512, 512, 537788160);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decim_frame.md
# decim_frame

Parametrised frame decimator for the incremental-ADC output path. It takes 2^osr_log2 accepted samples per conversion frame and emits one word per frame. Three modes are supported: sample-and-hold (last sample), sinc1 accumulate-and-dump, and sinc2 cascade-of-integrators. Integrators are reset per frame. It sits between the modulator output register and the readout/serialiser, and adds a valid strobe, a gated input, frame resync and a run-time ratio.

## Interface
Parameters:
- IN_W, default 12: input sample width, unsigned.
- MAX_LOG2, default 9: maximum log2 decimation ratio (N max = 512).
- OUT_W, default IN_W + 2*MAX_LOG2: output width, sized so sinc2 never overflows.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: sample qualifier; data_in is accepted on a rising edge with en=1.
- data_in, input, IN_W: unsigned sample.
- mode, input, 2: 0 = sample-hold, 1 = sinc1, 2 = sinc2, 3 = reserved (behaves as 1).
- osr_log2, input, clog2(MAX_LOG2+1): decimation ratio N = 2^min(osr_log2, MAX_LOG2).
- sync, input, 1: synchronous frame restart.
- data_out, output, OUT_W: frame result, held until the next frame completes.
- valid_out, output, 1: one-cycle pulse when data_out updates.

## Operation
- State: sample counter cnt (MAX_LOG2 bits, 0..N-1); accumulators acc1 (IN_W+MAX_LOG2) and acc2 (OUT_W); active config act_mode and act_log2.
- Config latch: mode and osr_log2 are latched into act_* on the edge that accepts the first sample of a frame (cnt==0, en=1). That first sample is processed with the newly latched config. Input changes mid-frame are ignored.
- Clamp: osr_log2 > MAX_LOG2 latches MAX_LOG2.
- Accept (en=1, sync=0):
  - a1n = acc1 + data_in
  - a2n = acc2 + a1n
  - Both accumulators start from 0 on the first sample of a frame.
- Last sample: cnt == N-1 with an accept.
  - data_out is loaded per act_mode: mode 0 = zero-extended data_in; mode 1/3 = a1n; mode 2 = a2n.
  - valid_out is set.
  - cnt, acc1 and acc2 are cleared.
- Otherwise, on an accept: cnt increments, acc1 <= a1n, acc2 <= a2n.
- All arithmetic is unsigned and full width; no truncation or scaling (normalisation is done downstream). Worst-case sinc2 result is (2^IN_W - 1)*N*(N+1)/2 < 2^OUT_W.
- en=0 (and sync=0): all state holds; valid_out = 0.
- sync=1 overrides en.
  - cnt, acc1 and acc2 are cleared; the sample on that edge is discarded.
  - No valid_out is generated; data_out holds its value.
  - The next accepted sample starts a new frame and relatches the config.
- Single-sample frames: with N=1, every accept is a last sample; valid_out may stay high on consecutive cycles.

## Timing
- Reset (rst_n=0 at an edge): data_out=0, valid_out=0, cnt=0, acc1=acc2=0, act_mode=0, act_log2=MAX_LOG2.
  - Reset mid-frame discards the partial frame.
  - Reset has priority over sync and en.
- Latency: data_out and valid_out become visible in the cycle after the edge that accepts the last sample (1 cycle, registered). valid_out is high for exactly one cycle unless the next edge is also a last-sample accept.
- With continuous en and N=512 in mode 0, the output cadence is one update per 512 clocks. The first update carries the 512th sample after reset.
- No back-pressure: the consumer must capture data_out within N accepted samples.

## Test plan
- Legacy mode: mode=0, osr_log2=9, en=1 continuously, data_in = cycle index mod 4096 starting at 0 after reset.
  - -> valid_out pulses every 512 cycles; data_out = 511, then 1023, then 1535.
- sinc1: mode=1, osr_log2=3, data_in=4095 constant, en=1.
  - -> data_out = 32760 every 8 cycles.
  - osr_log2=12 -> clamp to N=512, data_out = 2096640.
- sinc2: mode=2, osr_log2=2, samples 1,2,3,4.
  - -> data_out = 20 (acc1 1,3,6,10; acc2 1,4,10,20).
  - osr_log2=9, data_in=4095 -> data_out = 537788160, no overflow.
- Gated input: mode=1, osr_log2=2, en toggling 1,0,1,0,... with data_in = 10 when en=1 and 99 when en=0.
  - -> data_out = 40; valid_out one cycle after the 4th accepted sample.
- sync and config change:
  - mode=1, osr_log2=2, accept 5,5,5, then sync=1 with en=1 and data 7 -> no valid_out; data_out unchanged.
  - Then mode=2 with samples 1,1,1,1 -> data_out = 10.
  - Changing mode mid-frame has no effect on the current frame.
- N=1 and reset:
  - osr_log2=0, mode=1, en=1, data 3,4,5 -> valid_out high 3 consecutive cycles; data_out 3,4,5.
  - rst_n low mid-frame -> data_out=0, valid_out=0; the next frame counts from a fresh start.
